// File: rtl/board_scorer_if.sv
// Avalon-MM link between one master and one slave; ADDR_W sets the address width
// (4 bits for the host register port, 32 bits for the SDRAM port).
interface board_scorer_if #(
    parameter int ADDR_W = 32
);
    logic              waitrequest;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              write;
    logic [31:0]       writedata;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, read, write, writedata
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, read, write, writedata
    );
endinterface

// File: rtl/board_scorer.sv
// Scans an SDRAM array of 64-byte boards, scores material per board and keeps the best one.
// Optional macro SCORE_WRITEBACK_EN adds a per-board score writeback to the dst array.
module board_scorer #(
    parameter int BOARD_BYTES = 64,
    parameter int MAX_BOARDS  = 1024
) (
    input  logic           clk,
    input  logic           rst,
    board_scorer_if.slave  slave_bus,
    board_scorer_if.master master_bus
);
    localparam int SQ_W  = $clog2(BOARD_BYTES);
    localparam int CNT_W = $clog2(MAX_BOARDS + 1);
    localparam logic [SQ_W-1:0]  LAST_SQ    = SQ_W'(BOARD_BYTES - 1);
    localparam logic [SQ_W-1:0]  SQ_ZERO    = SQ_W'(1'b0);
    localparam logic [SQ_W-1:0]  SQ_ONE     = SQ_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_BOARDS);
    localparam logic [31:0]      NO_BOARD   = 32'hFFFF_FFFF;
    localparam logic [31:0]      WHITE_INIT = 32'h8000_0000;
    localparam logic [31:0]      BLACK_INIT = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        ACCUM   = 3'd3,
        CMP     = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6
`ifdef SCORE_WRITEBACK_EN
        , WB    = 3'd7
`endif
    } state_t;

    state_t             state_r, state_nx;
    logic [31:0]        src_r;
    logic [CNT_W-1:0]   count_r;
    logic               colour_r;
    logic [CNT_W-1:0]   board_r, board_nx;
    logic [SQ_W-1:0]    sq_r, sq_nx;
    logic signed [31:0] score_r, score_nx;
    logic [7:0]         piece_r, piece_nx;
    logic [31:0]        best_idx_r, best_idx_nx;
    logic signed [31:0] best_score_r, best_score_nx;
    logic               rd_r, rd_nx;
    logic [31:0]        addr_r, addr_nx;
    logic               start_s;
    logic               better_s;
    logic [31:0]        rdata_s;
`ifdef SCORE_WRITEBACK_EN
    logic [31:0]        dst_r;
    logic               wr_r, wr_nx;
    logic [31:0]        wdata_r, wdata_nx;
`endif

    // Material value of a signed piece code; black (negative) codes score negatively.
    function automatic logic signed [31:0] piece_value(input logic [7:0] code);
        logic [7:0]         mag_s;
        logic signed [31:0] val_s;
        mag_s = code[7] ? (8'd0 - code) : code;
        if (mag_s == 8'd0)       val_s = 32'sd0;
        else if (mag_s <= 8'd8)  val_s = 32'sd1;
        else if (mag_s <= 8'd18) val_s = 32'sd5;
        else if (mag_s <= 8'd38) val_s = 32'sd3;
        else if (mag_s <= 8'd47) val_s = 32'sd9;
        else                     val_s = 32'sd0;
        return code[7] ? -val_s : val_s;
    endfunction

    // Byte offset of a square: board*BOARD_BYTES + sq is a plain concatenation.
    function automatic logic [31:0] sq_offset(input logic [CNT_W-1:0] b, input logic [SQ_W-1:0] q);
        return {{(32-CNT_W-SQ_W){1'b0}}, b, q};
    endfunction

    assign start_s  = slave_bus.write && (slave_bus.address == 4'd0) && (state_r == IDLE);
    assign better_s = colour_r ? (score_r < best_score_r) : (score_r > best_score_r);

    // Host register reads: the result register stalls the host until the scan is over.
    always_comb begin
        rdata_s = 32'd0;
        case (slave_bus.address)
            4'd0:    rdata_s = best_idx_r;
            4'd5:    rdata_s = best_score_r;
            default: rdata_s = 32'd0;
        endcase
    end

    assign slave_bus.readdata      = rdata_s;
    assign slave_bus.waitrequest   = slave_bus.read && (slave_bus.address == 4'd0) && (state_r != IDLE);
    assign slave_bus.readdatavalid = slave_bus.read && !slave_bus.waitrequest;

    // Configuration registers; only accepted while idle so a running scan stays consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_r    <= 32'd0;
            count_r  <= CNT_ZERO;
            colour_r <= 1'b0;
`ifdef SCORE_WRITEBACK_EN
            dst_r    <= 32'd0;
`endif
        end else if (slave_bus.write && (state_r == IDLE)) begin
            case (slave_bus.address)
                4'd1: src_r <= slave_bus.writedata;
                4'd2: count_r <= (slave_bus.writedata > 32'(MAX_BOARDS)) ? CNT_MAX
                                                                         : slave_bus.writedata[CNT_W-1:0];
`ifdef SCORE_WRITEBACK_EN
                4'd3: dst_r <= slave_bus.writedata;
`endif
                4'd4: colour_r <= slave_bus.writedata[0];
                default: ;
            endcase
        end else begin
            src_r <= src_r;
        end
    end

    // Scan FSM next-state and datapath; bus strobes are computed one cycle ahead and registered.
    always_comb begin
        state_nx      = state_r;
        board_nx      = board_r;
        sq_nx         = sq_r;
        score_nx      = score_r;
        piece_nx      = piece_r;
        best_idx_nx   = best_idx_r;
        best_score_nx = best_score_r;
        rd_nx         = 1'b0;
        addr_nx       = addr_r;
`ifdef SCORE_WRITEBACK_EN
        wr_nx         = 1'b0;
        wdata_nx      = wdata_r;
`endif
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    best_idx_nx   = NO_BOARD;
                    best_score_nx = colour_r ? BLACK_INIT : WHITE_INIT;
                    board_nx      = CNT_ZERO;
                    sq_nx         = SQ_ZERO;
                    score_nx      = 32'sd0;
                    if (count_r == CNT_ZERO) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RD_REQ;
                        rd_nx    = 1'b1;
                        addr_nx  = src_r;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            RD_REQ: begin
                if (master_bus.waitrequest) begin
                    rd_nx = 1'b1;
                end else begin
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (master_bus.readdatavalid) begin
                    piece_nx = master_bus.readdata[7:0];
                    state_nx = ACCUM;
                end else begin
                    state_nx = RD_WAIT;
                end
            end
            ACCUM: begin
                score_nx = score_r + piece_value(piece_r);
                if (sq_r == LAST_SQ) begin
                    state_nx = CMP;
                end else begin
                    sq_nx    = sq_r + SQ_ONE;
                    state_nx = RD_REQ;
                    rd_nx    = 1'b1;
                    addr_nx  = src_r + sq_offset(board_r, sq_r + SQ_ONE);
                end
            end
            CMP: begin
                if (better_s) begin
                    best_idx_nx   = {{(32-CNT_W){1'b0}}, board_r};
                    best_score_nx = score_r;
                end else begin
                    best_idx_nx   = best_idx_r;
                end
`ifdef SCORE_WRITEBACK_EN
                state_nx = WB;
                wr_nx    = 1'b1;
                addr_nx  = dst_r + {{(30-CNT_W){1'b0}}, board_r, 2'b00};
                wdata_nx = score_r;
`else
                state_nx = NEXT;
`endif
            end
`ifdef SCORE_WRITEBACK_EN
            WB: begin
                if (master_bus.waitrequest) begin
                    wr_nx = 1'b1;
                end else begin
                    state_nx = NEXT;
                end
            end
`endif
            NEXT: begin
                if ((board_r + CNT_ONE) >= count_r) begin
                    state_nx = DONE;
                end else begin
                    board_nx = board_r + CNT_ONE;
                    sq_nx    = SQ_ZERO;
                    score_nx = 32'sd0;
                    state_nx = RD_REQ;
                    rd_nx    = 1'b1;
                    addr_nx  = src_r + sq_offset(board_r + CNT_ONE, SQ_ZERO);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan state and registered master-bus outputs; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            board_r      <= CNT_ZERO;
            sq_r         <= SQ_ZERO;
            score_r      <= 32'sd0;
            piece_r      <= 8'd0;
            best_idx_r   <= NO_BOARD;
            best_score_r <= WHITE_INIT;
            rd_r         <= 1'b0;
            addr_r       <= 32'd0;
`ifdef SCORE_WRITEBACK_EN
            wr_r         <= 1'b0;
            wdata_r      <= 32'd0;
`endif
        end else begin
            state_r      <= state_nx;
            board_r      <= board_nx;
            sq_r         <= sq_nx;
            score_r      <= score_nx;
            piece_r      <= piece_nx;
            best_idx_r   <= best_idx_nx;
            best_score_r <= best_score_nx;
            rd_r         <= rd_nx;
            addr_r       <= addr_nx;
`ifdef SCORE_WRITEBACK_EN
            wr_r         <= wr_nx;
            wdata_r      <= wdata_nx;
`endif
        end
    end

    assign master_bus.read    = rd_r;
    assign master_bus.address = addr_r;
`ifdef SCORE_WRITEBACK_EN
    assign master_bus.write     = wr_r;
    assign master_bus.writedata = wdata_r;
`else
    assign master_bus.write     = 1'b0;
    assign master_bus.writedata = 32'd0;
`endif
endmodule

// File: tb/tb_board_scorer.sv
// Bench for board_scorer: an SDRAM model with random stalls/latency checks every bus
// transaction against an expected-event queue built from a material-counting model.
module tb_board_scorer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    board_scorer_if #(.ADDR_W(4))  sl();
    board_scorer_if #(.ADDR_W(32)) mm();

    board_scorer dut (
        .clk        (clk),
        .rst        (rst),
        .slave_bus  (sl),
        .master_bus (mm)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mem [0:8191];
    ev_t         exp_q[$];
    bit          stall_mode   = 1'b0;
    int          read_strobes = 0;
    logic [31:0] last_rd_addr = 32'd0;
    int          back_rank[8] = '{10, 20, 30, 40, 48, 31, 21, 11};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Reference piece values straight from the material table.
    function automatic int piece_val(input logic [7:0] code);
        int c, m, v;
        c = int'($signed(code));
        m = (c < 0) ? -c : c;
        if (m >= 1 && m <= 8)        v = 1;
        else if (m >= 9 && m <= 18)  v = 5;
        else if (m >= 19 && m <= 38) v = 3;
        else if (m >= 39 && m <= 47) v = 9;
        else                         v = 0;
        return (c < 0) ? -v : v;
    endfunction

    function automatic int board_score(input logic [31:0] base, input int b);
        int s = 0;
        for (int q = 0; q < 64; q++) s += piece_val(mem[(base + 32'(b * 64 + q)) & 32'h1FFF]);
        return s;
    endfunction

    task automatic load_start(input logic [31:0] base);
        for (int q = 0; q < 64; q++) mem[(base + 32'(q)) & 32'h1FFF] = 8'd0;
        for (int c = 0; c < 8; c++) begin
            mem[(base + 32'(c)) & 32'h1FFF]      = 8'(back_rank[c]);
            mem[(base + 32'(8 + c)) & 32'h1FFF]  = 8'(c + 1);
            mem[(base + 32'(48 + c)) & 32'h1FFF] = 8'(-(c + 1));
            mem[(base + 32'(56 + c)) & 32'h1FFF] = 8'(-back_rank[c]);
        end
    endtask

    task automatic load_random(input logic [31:0] base, input int boards);
        for (int i = 0; i < boards * 64; i++)
            mem[(base + 32'(i)) & 32'h1FFF] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                                          : 8'(int'($urandom_range(0, 96)) - 48);
    endtask

    // SDRAM model and per-cycle bus checker: sampled on the falling edge.
    initial begin : bus_model
        bit          wr_stall, pend_valid, prev_stall_rd, prev_stall_wr;
        int          pend_cnt;
        logic [31:0] pend_addr, prev_addr, prev_wdata, rnd;
        ev_t         ev;
        pend_valid = 1'b0; pend_cnt = 0; pend_addr = 32'd0;
        prev_stall_rd = 1'b0; prev_stall_wr = 1'b0; prev_addr = 32'd0; prev_wdata = 32'd0;
        mm.waitrequest = 1'b0; mm.readdatavalid = 1'b0; mm.readdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_valid = 1'b0; prev_stall_rd = 1'b0; prev_stall_wr = 1'b0;
                mm.readdatavalid = 1'b0; mm.waitrequest = 1'b0;
                continue;
            end
            if (prev_stall_rd) begin
                check("rd_held", 32'(mm.read), 32'd1);
                check("rd_addr_held", mm.address, prev_addr);
            end
            if (prev_stall_wr) begin
                check("wr_held", 32'(mm.write), 32'd1);
                check("wr_addr_held", mm.address, prev_addr);
                check("wr_data_held", mm.writedata, prev_wdata);
            end
            mm.readdatavalid = 1'b0;
            if (pend_valid) begin
                if (pend_cnt == 0) begin
                    rnd = $urandom();
                    mm.readdata = {rnd[31:8], mem[pend_addr & 32'h1FFF]};
                    mm.readdatavalid = 1'b1;
                    pend_valid = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            wr_stall = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
            mm.waitrequest = wr_stall;
            if (mm.read) read_strobes++;
            if (mm.read && !wr_stall) begin
                check("one_outstanding", 32'(pend_valid), 32'd0);
                last_rd_addr = mm.address;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: address %h, no transaction expected", mm.address);
                end else begin
                    ev = exp_q.pop_front();
                    check("rd_is_next_event", 32'(ev.is_wr), 32'd0);
                    check("rd_addr", mm.address, ev.addr);
                end
                pend_valid = 1'b1;
                pend_cnt   = stall_mode ? int'($urandom_range(0, 5)) : 0;
                pend_addr  = mm.address;
            end
            if (mm.write && !wr_stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: address %h data %h", mm.address, mm.writedata);
                end else begin
                    ev = exp_q.pop_front();
                    check("wr_is_next_event", 32'(ev.is_wr), 32'd1);
                    check("wr_addr", mm.address, ev.addr);
                    check("wr_data", mm.writedata, ev.data);
                end
            end
            prev_stall_rd = mm.read && wr_stall;
            prev_stall_wr = mm.write && wr_stall;
            prev_addr     = mm.address;
            prev_wdata    = mm.writedata;
        end
    end

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        sl.address = a; sl.writedata = d; sl.write = 1'b1;
        @(posedge clk); #1;
        sl.write = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, input int budget, output logic [31:0] d, output bit ok);
        ok = 1'b0; d = 32'd0;
        sl.address = a; sl.read = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!sl.waitrequest) begin ok = 1'b1; d = sl.readdata; end
            @(posedge clk); #1;
        end
        sl.read = 1'b0;
    endtask

    task automatic start_scan(input logic [31:0] src, input int cnt, input bit colour, input logic [31:0] dst);
        ev_t ev;
        exp_q.delete();
        for (int b = 0; b < cnt; b++) begin
            for (int q = 0; q < 64; q++) begin
                ev.is_wr = 1'b0; ev.addr = src + 32'(b * 64 + q); ev.data = 32'd0;
                exp_q.push_back(ev);
            end
`ifdef SCORE_WRITEBACK_EN
            ev.is_wr = 1'b1; ev.addr = dst + 32'(4 * b); ev.data = 32'(board_score(src, b));
            exp_q.push_back(ev);
`endif
        end
        reg_write(4'd1, src);
        reg_write(4'd2, 32'(cnt));
        reg_write(4'd3, dst);
        reg_write(4'd4, 32'(colour));
        reg_write(4'd0, 32'd0);
    endtask

    task automatic finish_scan(input logic [31:0] src, input int cnt, input bit colour,
                               output logic [31:0] got_idx, output logic [31:0] got_score);
        logic [31:0] exp_idx;
        int          bs, s;
        bit          ok;
        exp_idx = 32'hFFFF_FFFF;
        bs = colour ? int'(32'h7FFF_FFFF) : int'(32'h8000_0000);
        for (int b = 0; b < cnt; b++) begin
            s = board_score(src, b);
            if (colour ? (s < bs) : (s > bs)) begin bs = s; exp_idx = 32'(b); end
        end
        reg_read(4'd0, 20000, got_idx, ok);
        check("scan_completes", 32'(ok), 32'd1);
        check("best_idx", got_idx, exp_idx);
        reg_read(4'd5, 4, got_score, ok);
        check("best_score", got_score, 32'(bs));
        check("all_transactions_seen", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] d, idx0, sc0, idx1, sc1;
        bit          ok;
        int          strobes_before, rnd_col;
        sl.address = 4'd0; sl.read = 1'b0; sl.write = 1'b0; sl.writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_slave_waitrequest", 32'(sl.waitrequest), 32'd0);
        check("rst_master_read", 32'(mm.read), 32'd0);
        check("rst_master_write", 32'(mm.write), 32'd0);
        check("rst_master_address", mm.address, 32'd0);
        check("rst_master_writedata", mm.writedata, 32'd0);
        reg_read(4'd0, 4, d, ok);
        check("rst_best_idx", d, 32'hFFFF_FFFF);
        reg_read(4'd5, 4, d, ok);
        check("rst_best_score", d, 32'h8000_0000);
        reg_read(4'd7, 4, d, ok);
        check("unmapped_read", d, 32'd0);

        // Starting position: balanced material.
        load_start(32'h200);
        check("model_start_pos", 32'(board_score(32'h200, 0)), 32'd0);
        start_scan(32'h200, 1, 1'b0, 32'h0);
        finish_scan(32'h200, 1, 1'b0, idx0, sc0);
        check("start_pos_idx", idx0, 32'd0);
        check("start_pos_score", sc0, 32'd0);

        // Three boards: black queen, black knight, black queen captured.
        load_start(32'h400); load_start(32'h440); load_start(32'h480);
        mem[32'h400 + 59] = 8'd0;
        mem[32'h440 + 57] = 8'd0;
        mem[32'h480 + 59] = 8'd0;
        check("model_board0", 32'(board_score(32'h400, 0)), 32'd9);
        check("model_board1", 32'(board_score(32'h400, 1)), 32'd3);
        start_scan(32'h400, 3, 1'b0, 32'h0);
        finish_scan(32'h400, 3, 1'b0, idx0, sc0);
        check("white_tie_idx", idx0, 32'd0);
        check("white_score", sc0, 32'd9);
        start_scan(32'h400, 3, 1'b1, 32'h0);
        finish_scan(32'h400, 3, 1'b1, idx0, sc0);
        check("black_idx", idx0, 32'd1);
        check("black_score", sc0, 32'd3);

        // Empty scan: immediate result, no memory traffic.
        strobes_before = read_strobes;
        start_scan(32'h400, 0, 1'b0, 32'h0);
        reg_read(4'd0, 3, d, ok);
        check("count0_fast", 32'(ok), 32'd1);
        check("count0_idx", d, 32'hFFFF_FFFF);
        reg_read(4'd5, 4, d, ok);
        check("count0_white_score", d, 32'h8000_0000);
        start_scan(32'h400, 0, 1'b1, 32'h0);
        finish_scan(32'h400, 0, 1'b1, idx0, sc0);
        check("count0_black_score", sc0, 32'h7FFF_FFFF);
        check("count0_no_reads", 32'(read_strobes), 32'(strobes_before));

        // Random two-board run, zero-wait then stalled with random latency.
        load_random(32'h800, 2);
        rnd_col = int'($urandom_range(0, 1));
        start_scan(32'h800, 2, 1'(rnd_col), 32'h0);
        finish_scan(32'h800, 2, 1'(rnd_col), idx0, sc0);
        stall_mode = 1'b1;
        start_scan(32'h800, 2, 1'(rnd_col), 32'h0);
        finish_scan(32'h800, 2, 1'(rnd_col), idx1, sc1);
        check("stall_same_idx", idx1, idx0);
        check("stall_same_score", sc1, sc0);

        // Reset while board 1 of a four-board run is being read.
        load_random(32'hC00, 4);
        last_rd_addr = 32'd0;
        start_scan(32'hC00, 4, 1'b0, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (last_rd_addr >= 32'hC40) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("reached_board1", 32'(ok), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_read_low", 32'(mm.read), 32'd0);
        check("abort_write_low", 32'(mm.write), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        reg_read(4'd0, 4, d, ok);
        check("abort_best_idx", d, 32'hFFFF_FFFF);
        start_scan(32'hC00, 4, 1'b0, 32'h0);
        finish_scan(32'hC00, 4, 1'b0, idx0, sc0);

`ifdef SCORE_WRITEBACK_EN
        // Writeback of each board's score, interleaved before the next board's reads.
        load_random(32'h1800, 3);
        start_scan(32'h1800, 3, 1'b0, 32'h1000);
        finish_scan(32'h1800, 3, 1'b0, idx0, sc0);
`endif
        stall_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
